// File: rtl/adc_channel_sequencer.sv
// Round-robin scan sequencer for the LTC2308 SPI core: drives start/channel/sleep, undoes the core's
// one-frame config pipeline and queues channel-tagged samples in a small valid/ready FIFO.
module adc_channel_sequencer #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned FRAME_CYCLES  = 80,
    parameter bit          SLEEP_ON_STOP = 1'b0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [7:0]  ch_mask,
    input  logic        diff_mode,
    input  logic        clear_ovf,
    output logic        adc_start,
    output logic        adc_sleep,
    output logic [3:0]  adc_channel,
    input  logic        adc_ready,
    input  logic [11:0] adc_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_channel,
    output logic [11:0] out_data,
    output logic        busy,
    output logic        overflow
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FRAME_CYCLES + 1);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] FRAME_C = CW'(FRAME_CYCLES);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PRIME = 2'd1, S_RUN = 2'd2, S_DRAIN = 2'd3} state_t;

    state_t          state_q, state_d;
    logic [7:0]      mask_q, mask_d;
    logic            diff_q, diff_d;
    logic [2:0]      cur_ch_q, cur_ch_d;
    logic [2:0]      prev_ch_q, prev_ch_d;
    logic            prime_q, prime_d;
    logic [CW-1:0]   drain_cnt_q, drain_cnt_d;
    logic            drain_seen_q, drain_seen_d;
    logic            start_q, start_d;
    logic            sleep_q, sleep_d;
    logic            overflow_q, overflow_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [15:0]     mem_q [FIFO_DEPTH];
    logic            frame_evt_s, emit_s, push_s, pop_s, full_s;
    logic [AW:0]     count_s;

    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Searching farthest-first leaves the nearest enabled successor; no other bit keeps cur.
    function automatic logic [2:0] next_ch(input logic [2:0] cur, input logic [7:0] m);
        logic [2:0] r;
        logic [2:0] c;
        r = cur;
        for (int k = 7; k >= 1; k--) begin
            c = cur + 3'(k);
            if (m[c]) r = c;
        end
        return r;
    endfunction

    // Next-state, frame-boundary bookkeeping and FIFO control.
    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        diff_d       = diff_q;
        cur_ch_d     = cur_ch_q;
        prev_ch_d    = prev_ch_q;
        prime_d      = prime_q;
        drain_cnt_d  = drain_cnt_q;
        drain_seen_d = drain_seen_q;
        start_d      = start_q;
        sleep_d      = sleep_q;

        frame_evt_s = adc_ready && ((state_q == S_PRIME) || (state_q == S_RUN) ||
                                    ((state_q == S_DRAIN) && !drain_seen_q));
        emit_s      = frame_evt_s && !prime_q;
        if (frame_evt_s) begin
            prev_ch_d = cur_ch_q;
            cur_ch_d  = next_ch(cur_ch_q, mask_q);
            prime_d   = 1'b0;
        end else begin
            prime_d   = prime_q;
        end

        case (state_q)
            S_IDLE: begin
                if (enable && (ch_mask != 8'd0)) begin
                    state_d  = S_PRIME;
                    mask_d   = ch_mask;
                    diff_d   = diff_mode;
                    cur_ch_d = lowest_set(ch_mask);
                    prime_d  = 1'b1;
                    start_d  = 1'b1;
                end else begin
                    start_d  = 1'b0;
                end
            end
            S_PRIME, S_RUN: begin
                if (!enable) begin
                    state_d      = S_DRAIN;
                    start_d      = 1'b0;
                    sleep_d      = SLEEP_ON_STOP;
                    drain_cnt_d  = FRAME_C;
                    drain_seen_d = 1'b0;
                end else if (adc_ready) begin
                    state_d      = S_RUN;
                end else begin
                    state_d      = state_q;
                end
            end
            S_DRAIN: begin
                if (adc_ready) begin
                    drain_seen_d = 1'b1;
                end else begin
                    drain_seen_d = drain_seen_q;
                end
                if (drain_cnt_q == '0) begin
                    state_d     = S_IDLE;
                    sleep_d     = 1'b0;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                start_d = 1'b0;
                sleep_d = 1'b0;
            end
        endcase

        count_s  = wr_ptr_q - rd_ptr_q;
        full_s   = (count_s == DEPTH_C);
        pop_s    = (count_s != '0) && out_ready;
        push_s   = emit_s && (!full_s || pop_s);
        wr_ptr_d = push_s ? (wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop_s ? (rd_ptr_q + 1'b1) : rd_ptr_q;

        // A drop in the same cycle as clear_ovf must still leave the flag set.
        overflow_d = clear_ovf ? 1'b0 : overflow_q;
        if (emit_s && full_s && !pop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_d;
        end
    end

    // Control and status registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            mask_q       <= 8'd0;
            diff_q       <= 1'b0;
            cur_ch_q     <= 3'd0;
            prev_ch_q    <= 3'd0;
            prime_q      <= 1'b0;
            drain_cnt_q  <= '0;
            drain_seen_q <= 1'b0;
            start_q      <= 1'b0;
            sleep_q      <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            diff_q       <= diff_d;
            cur_ch_q     <= cur_ch_d;
            prev_ch_q    <= prev_ch_d;
            prime_q      <= prime_d;
            drain_cnt_q  <= drain_cnt_d;
            drain_seen_q <= drain_seen_d;
            start_q      <= start_d;
            sleep_q      <= sleep_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // Sample storage; the tag is the mode driven one frame before this sample returned.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= 16'd0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {diff_q, prev_ch_q, adc_data};
        end
    end

    assign adc_start   = start_q;
    assign adc_sleep   = sleep_q;
    assign adc_channel = {diff_q, cur_ch_q};
    assign out_valid   = (count_s != '0);
    assign out_channel = mem_q[rd_ptr_q[AW-1:0]][15:12];
    assign out_data    = mem_q[rd_ptr_q[AW-1:0]][11:0];
    assign busy        = (state_q != S_IDLE);
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_adc_channel_sequencer.sv
// Bench for adc_channel_sequencer: LTC2308-style core model with one-frame config pipeline,
// scan order predicted from the channel mask, scoreboard of tagged samples.
module tb_adc_channel_sequencer;
    localparam int DEPTH      = 4;
    localparam int FRAME      = 20;
    localparam int CORE_FRAME = 16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  ch_mask = 8'd0;
    logic        diff_mode = 1'b0;
    logic        clear_ovf = 1'b0;
    logic        adc_start, adc_sleep, out_valid, busy, overflow;
    logic [3:0]  adc_channel, out_channel;
    logic [11:0] out_data;
    logic        adc_ready;
    logic [11:0] adc_data;
    logic        out_ready = 1'b0;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          rand_rdy = 1'b0;
    bit          core_busy;
    int          core_cnt;
    logic [3:0]  core_cfg, core_conv;
    logic [3:0]  cfg_log[$];
    logic [15:0] smp_log[$];
    logic [15:0] got_q[$];

    adc_channel_sequencer #(.FIFO_DEPTH(DEPTH), .FRAME_CYCLES(FRAME), .SLEEP_ON_STOP(1'b0)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .ch_mask(ch_mask),
        .diff_mode(diff_mode), .clear_ovf(clear_ovf), .adc_start(adc_start),
        .adc_sleep(adc_sleep), .adc_channel(adc_channel), .adc_ready(adc_ready),
        .adc_data(adc_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_channel(out_channel), .out_data(out_data), .busy(busy), .overflow(overflow)
    );

    always #5 clock = ~clock;

    // Core model: config latched during frame n selects conversion n+1.
    initial begin
        adc_ready = 1'b0; adc_data = 12'd0; core_busy = 1'b0; core_cnt = 0;
        core_cfg = 4'd0; core_conv = 4'd0;
        forever begin
            @(posedge clock); #1;
            adc_ready = 1'b0;
            if (!reset_n) begin
                core_busy = 1'b0;
                core_cnt  = 0;
            end else if (core_busy) begin
                core_cnt++;
                if (core_cnt == 2) begin
                    core_cfg = adc_channel;
                    cfg_log.push_back(adc_channel);
                end
                if (core_cnt == CORE_FRAME - 1) begin
                    adc_ready = 1'b1;
                    adc_data  = 12'($urandom);
                    smp_log.push_back({core_conv, adc_data});
                    core_conv = core_cfg;
                    core_busy = 1'b0;
                end
            end else if (adc_start) begin
                core_busy = 1'b1;
                core_cnt  = 0;
            end
        end
    end

    // Consumer-side recorder of accepted words.
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n && out_valid && out_ready) got_q.push_back({out_channel, out_data});
        end
    end

    function automatic logic [3:0] exp_mode(input logic [7:0] m, input logic d, input int n);
        int bits[$];
        for (int i = 0; i < 8; i++) if (m[i]) bits.push_back(i);
        return {d, 3'(bits[n % bits.size()])};
    endfunction

    task automatic tick();
        @(posedge clock); #2;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic start_scan(input logic [7:0] m, input logic d);
        got_q.delete(); cfg_log.delete(); smp_log.delete();
        ch_mask = m; diff_mode = d; enable = 1'b1;
        tick();
    endtask

    task automatic wait_frames(input int n);
        int t = 0;
        while (smp_log.size() < n && t < n * CORE_FRAME * 3 + 50) begin tick(); t++; end
        n_cmp++;
        if (smp_log.size() < n) begin
            n_bad++; $display("FAIL wait_frames: got %0d frames, need %0d", smp_log.size(), n);
        end
    endtask

    task automatic stop_and_drain();
        int t = 0;
        enable = 1'b0;
        while (busy && t < FRAME + 5) begin tick(); t++; end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL drain_timeout: busy=%b want 0", busy); end
        rand_rdy = 1'b0; out_ready = 1'b1; t = 0;
        while (out_valid && t < 50) begin tick(); t++; end
    endtask

    task automatic check_stream(input logic [7:0] m, input logic d, input string nm);
        int f = smp_log.size();
        for (int n = 0; n < f && n < cfg_log.size(); n++) begin
            n_cmp++;
            if (cfg_log[n] !== exp_mode(m, d, n)) begin
                n_bad++; $display("FAIL %s cfg[%0d]: got %h want %h", nm, n, cfg_log[n], exp_mode(m, d, n));
            end
        end
        n_cmp++;
        if (got_q.size() != f - 1) begin
            n_bad++; $display("FAIL %s count: got %0d want %0d", nm, got_q.size(), f - 1);
        end
        for (int j = 0; j < f - 1 && j < got_q.size(); j++) begin
            n_cmp++;
            if (got_q[j] !== {exp_mode(m, d, j), smp_log[j+1][11:0]}) begin
                n_bad++;
                $display("FAIL %s word[%0d]: got %h want %h", nm, j, got_q[j], {exp_mode(m, d, j), smp_log[j+1][11:0]});
            end
        end
        n_cmp++;
        if (overflow !== 1'b0) begin n_bad++; $display("FAIL %s ovf: got %b want 0", nm, overflow); end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({adc_start, adc_sleep, adc_channel, out_valid, out_channel, out_data, busy, overflow} !== 24'd0) begin
            n_bad++; $display("FAIL reset_outputs: got %h want 0",
                {adc_start, adc_sleep, adc_channel, out_valid, out_channel, out_data, busy, overflow});
        end
        tick(); reset_n = 1'b1; tick();
        n_cmp++;
        if ({busy, adc_start, out_valid} !== 3'b000) begin
            n_bad++; $display("FAIL reset_idle: got %b want 000", {busy, adc_start, out_valid});
        end
    endtask

    task automatic test_scan(input logic [7:0] m, input logic d, input int frames, input string nm);
        rand_rdy = 1'b1;
        start_scan(m, d);
        wait_frames(frames);
        stop_and_drain();
        check_stream(m, d, nm);
    endtask

    task automatic test_overflow();
        logic [7:0] m = 8'($urandom_range(1, 255));
        logic       d = 1'($urandom_range(0, 1));
        int t = 0;
        rand_rdy = 1'b0; out_ready = 1'b0;
        start_scan(m, d);
        wait_frames(6);
        stop_and_drain_hold();
        n_cmp++;
        if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_hold_valid: got %b want 1", out_valid); end
        out_ready = 1'b1;
        while (out_valid && t < 20) begin tick(); t++; end
        n_cmp++;
        if (got_q.size() != DEPTH) begin n_bad++; $display("FAIL ovf_count: got %0d want %0d", got_q.size(), DEPTH); end
        for (int j = 0; j < DEPTH && j < got_q.size(); j++) begin
            n_cmp++;
            if (got_q[j] !== {exp_mode(m, d, j), smp_log[j+1][11:0]}) begin
                n_bad++; $display("FAIL ovf_word[%0d]: got %h want %h", j, got_q[j], {exp_mode(m, d, j), smp_log[j+1][11:0]});
            end
        end
        n_cmp++;
        if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    endtask

    task automatic stop_and_drain_hold();
        int t = 0;
        enable = 1'b0;
        while (busy && t < FRAME + 5) begin tick(); t++; end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL ovf_drain: busy=%b want 0", busy); end
    endtask

    task automatic test_stop_mid_frame();
        logic [7:0] m = 8'($urandom_range(1, 255));
        int t = 0;
        int f0;
        bit started = 1'b0;
        rand_rdy = 1'b0; out_ready = 1'b1;
        start_scan(m, 1'b0);
        wait_frames(3);
        while (!(core_busy && core_cnt == 8) && t < 100) begin tick(); t++; end
        f0 = smp_log.size();
        enable = 1'b0; t = 0;
        while (busy && t < FRAME + 5) begin tick(); t++; end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL stop_busy: got %b want 0 after %0d clocks", busy, t); end
        n_cmp++;
        if (smp_log.size() != f0 + 1) begin
            n_bad++; $display("FAIL stop_frames: got %0d want %0d", smp_log.size(), f0 + 1);
        end
        for (int i = 0; i < 30; i++) begin tick(); if (adc_start) started = 1'b1; end
        n_cmp++;
        if (started) begin n_bad++; $display("FAIL stop_no_restart: adc_start seen, want none"); end
        check_stream(m, 1'b0, "stop_mid_frame");
    endtask

    task automatic test_zero_mask();
        bit seen = 1'b0;
        ch_mask = 8'd0; enable = 1'b1;
        for (int i = 0; i < 20; i++) begin tick(); if (busy || adc_start) seen = 1'b1; end
        enable = 1'b0;
        n_cmp++;
        if (seen) begin n_bad++; $display("FAIL zero_mask: busy/adc_start seen, want idle"); end
    endtask

    task automatic test_async_reset();
        rand_rdy = 1'b0; out_ready = 1'b0;
        start_scan(8'($urandom_range(1, 255)), 1'b0);
        wait_frames(3);
        tick();
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_pre_valid: got %b want 1", out_valid); end
        #1 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, adc_start, busy, out_data} !== 15'd0) begin
            n_bad++; $display("FAIL rst_async: got %h want 0", {out_valid, adc_start, busy, out_data});
        end
        enable = 1'b0;
        tick(); tick(); reset_n = 1'b1; tick();
        n_cmp++;
        if ({out_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL rst_after: got %b want 00", {out_valid, busy}); end
    endtask

    initial begin
        test_reset();
        test_scan(8'h05, 1'b0, 6, "rr_05");
        test_scan(8'h80, 1'b1, 4, "single_80_diff");
        for (int k = 0; k < 3; k++)
            test_scan(8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)), 7, "rand_mask");
        test_overflow();
        test_stop_mid_frame();
        test_zero_mask();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
